simd_accumulator: RTL and testbench
===================================

// Module: simd_accumulator
// PURPOSE
//  Downstream stage of the SIMD multiplier (smul) in the DTPU MAC datapath.
//  - Consumes 64-bit packed product vectors and accumulates them per lane (8/16/32/64-bit lanes).
//  - Closes a group on a last-beat flag and presents the packed result over a valid/ready handshake.
//  - Reports sticky per-lane signed overflow.
// PARAMETERS
//  DATA_WIDTH  64  packed vector width; fixed multiple of 64, one byte-overflow bit per 8 bits
//  CNT_WIDTH   8   beat-counter width; max group length 2**CNT_WIDTH-1 beats
// PORTS
//  clk               in   1             single clock, rising edge
//  aresetn           in   1             asynchronous active-low reset
//  sclr              in   1             synchronous clear, priority over ce
//  ce                in   1             clock enable; low freezes all state and outputs
//  active_chain      in   1             1 = accumulate over a group; 0 = pass-through, every beat is last
//  select_precision  in   4             1=8b, 3=16b, 7=32b, F=64b lanes; other codes are treated as 8b
//  in_valid          in   1             product beat valid
//  in_last           in   1             beat closes the group
//  res_mac_p         in   DATA_WIDTH    packed product vector from smul
//  in_ready          out  1             beat accepted when in_valid&in_ready&ce
//  acc_out           out  DATA_WIDTH    packed accumulated result
//  out_valid         out  1             acc_out valid
//  out_ready         in   1             consumer takes result when out_valid&out_ready&ce
//  overflow          out  DATA_WIDTH/8  sticky signed overflow; bit at the lane's top byte, others 0
//  beat_count        out  CNT_WIDTH     beats accepted in the current group
// BEHAVIOUR
//  - Reset (aresetn=0, async) and sclr: state=IDLE, acc=0, acc_out=0, out_valid=0, in_ready=0
//    during reset, overflow=0, beat_count=0. in_ready=1 in the first cycle after reset release.
//  - FSM states: IDLE, ACC, HOLD.
//    - IDLE: in_ready=1. Accepted beat: acc<=res_mac_p, latch precision, count<=1.
//      -> HOLD if last, else -> ACC.
//    - ACC: in_ready=1. Accepted beat: acc<=acc+res_mac_p (lane-segmented), count++.
//      -> HOLD if last.
//    - HOLD: in_ready=0, out_valid=1, acc_out=acc stable. On out_ready -> IDLE, acc, overflow and
//      count cleared. No beat accepted in the same cycle; one bubble per group.
//  - "last" = in_last | ~active_chain | (count==2**CNT_WIDTH-2 on the accepting beat).
//    A group of max length is force-closed.
//  - Latency: out_valid rises on the edge that accepts the last beat; acc_out is registered.
//  - Precision:
//    - Latched on the first beat of a group; select_precision changes mid-group are ignored.
//    - Carry is killed at lane boundaries.
//    - Lane sums wrap modulo 2**lane_width in two's complement.
//  - Overflow: a lane's bit is set when both operands have the same sign and the sum's sign differs.
//    It is sticky until the group is consumed. The first beat never sets overflow.
//  - ce=0: no state change, no accept, no consume; in_ready and out_valid hold their values.
//  - Simultaneous sclr and accept: sclr wins and the beat is dropped.
//  - aresetn mid-group: the group is discarded, no output.
// STRUCTURE
//  - Package dtpu_pkg:
//    - PREC_8=4'h1, PREC_16=4'h3, PREC_32=4'h7, PREC_64=4'hF.
//    - acc_state_t enum {IDLE, ACC, HOLD}.
//    - Function prec_lane_mask(prec) returning the DATA_WIDTH/8 carry-kill mask.
//  - Sub-module simd_lane_adder: combinational segmented adder.
//    - Inputs: a, b, lane mask. Outputs: sum, per-byte overflow.
//    - Instantiated once; the FSM, counter and registers stay in simd_accumulator.
// TESTING
//  - 8b, active_chain=1: 3 beats {8{8'h01}}, last on 3rd
//    -> acc_out={8{8'h03}}, out_valid the cycle after, overflow=0.
//  - 8b wrap: {8{8'h7F}} then {8{8'h01}} last -> acc_out={8{8'h80}}, overflow=8'hFF.
//  - 16b: {4{16'hCAFE}} + {4{16'h0002}} -> {4{16'hCB00}}, byte carry propagates, overflow=0;
//    same stimulus at 8b -> {4{16'hCA00}}.
//  - 64b: 64'hFFFF_FFFF_FFFF_FFFF + 64'h1 -> 0, overflow=0.
//    Then 64'h7FFF_FFFF_FFFF_FFFF + 1 -> overflow=8'h80.
//  - active_chain=0: beats 64'h1234 and 64'h5678 back-to-back with out_ready=1 -> two results
//    64'h1234, 64'h5678, one bubble between.
//  - Backpressure/reset: out_ready=0 for 3 cycles -> in_ready=0 and acc_out stable.
//    Precision toggled mid-group -> ignored.
//    aresetn pulsed after 2 beats -> all outputs 0, the next group starts clean.

Source files
------------

// File: rtl/dtpu_pkg.sv
// Shared types and helpers for the DTPU MAC datapath: precision codes,
// accumulator FSM states and the lane carry-kill mask.
package dtpu_pkg;

  localparam logic [3:0] PREC_8  = 4'h1;
  localparam logic [3:0] PREC_16 = 4'h3;
  localparam logic [3:0] PREC_32 = 4'h7;
  localparam logic [3:0] PREC_64 = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_t;

  // Mask for one 64-bit slice: bit i set means byte i is the top byte of a lane,
  // so its carry-out is killed and its sign bit is the lane sign. Unknown codes act as 8b.
  function automatic logic [7:0] prec_lane_mask(input logic [3:0] prec);
    logic [7:0] mask;
    case (prec)
      PREC_16: mask = 8'hAA;
      PREC_32: mask = 8'h88;
      PREC_64: mask = 8'h80;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/simd_lane_adder.sv
// Combinational byte-chained adder whose carry chain is broken at lane tops;
// flags signed overflow at each lane's top byte.
module simd_lane_adder #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  input  logic [DATA_WIDTH/8-1:0] lane_mask_i,
  output logic [DATA_WIDTH-1:0]   sum_o,
  output logic [DATA_WIDTH/8-1:0] ovf_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic       carry;
  logic [8:0] byte_sum;

  always_comb begin
    sum_o    = '0;
    ovf_o    = '0;
    carry    = 1'b0;
    byte_sum = '0;
    for (int i = 0; i < NB; i++) begin
      byte_sum = {1'b0, a_i[8*i +: 8]} + {1'b0, b_i[8*i +: 8]} + {8'b0, carry};
      sum_o[8*i +: 8] = byte_sum[7:0];
      ovf_o[i] = lane_mask_i[i] & (a_i[8*i+7] == b_i[8*i+7]) & (byte_sum[7] != a_i[8*i+7]);
      carry = byte_sum[8] & ~lane_mask_i[i];
    end
  end

endmodule

// File: rtl/simd_accumulator.sv
// Per-lane accumulator behind the SIMD multiplier: sums product beats of a group
// and hands the packed result over a valid/ready handshake with sticky overflow.
//
// state | meaning
// IDLE  | waiting for the first beat of a group
// ACC   | group open, adding beats into acc
// HOLD  | result presented on acc_out, waiting for out_ready
module simd_accumulator
  import dtpu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    sclr,
  input  logic                    ce,
  input  logic                    active_chain,
  input  logic [3:0]              select_precision,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [DATA_WIDTH-1:0]   res_mac_p,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   acc_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH/8-1:0] overflow,
  output logic [CNT_WIDTH-1:0]    beat_count
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] CNT_CLOSE = {{(CNT_WIDTH-1){1'b1}}, 1'b0};

  acc_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] acc_out_q, acc_out_d;
  logic [NB-1:0]         ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [3:0]            prec_q, prec_d;

  logic [NB-1:0]         lane_mask;
  logic [DATA_WIDTH-1:0] add_sum;
  logic [NB-1:0]         add_ovf;
  logic                  accept;
  logic                  consume;
  logic                  is_last;

  assign lane_mask = {(DATA_WIDTH/64){prec_lane_mask(prec_q)}};

  simd_lane_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
    .a_i         (acc_q),
    .b_i         (res_mac_p),
    .lane_mask_i (lane_mask),
    .sum_o       (add_sum),
    .ovf_o       (add_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    prec_d    = prec_q;
    accept    = ce & in_valid & (state_q != HOLD);
    consume   = ce & out_ready & (state_q == HOLD);
    // A group that reaches the counter ceiling is closed so beat_count never wraps.
    is_last   = in_last | ~active_chain | (cnt_q == CNT_CLOSE);

    if (sclr) begin
      state_d   = IDLE;
      acc_d     = '0;
      acc_out_d = '0;
      ovf_d     = '0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = res_mac_p;
            prec_d  = select_precision;
            cnt_d   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            ovf_d   = '0;
            if (is_last) begin
              state_d   = HOLD;
              acc_out_d = res_mac_p;
            end else begin
              state_d   = ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc_d = add_sum;
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            ovf_d = ovf_q | add_ovf;
            if (is_last) begin
              state_d   = HOLD;
              acc_out_d = add_sum;
            end
          end
        end
        HOLD: begin
          if (consume) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      acc_out_q <= '0;
      ovf_q     <= '0;
      cnt_q     <= '0;
      prec_q    <= PREC_8;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      prec_q    <= prec_d;
    end
  end

  // Gated by aresetn so the port reads 0 while reset is held and 1 right after release.
  assign in_ready   = aresetn & (state_q != HOLD);
  assign out_valid  = (state_q == HOLD);
  assign acc_out    = acc_out_q;
  assign overflow   = ovf_q;
  assign beat_count = cnt_q;

endmodule

// File: tb/tb_simd_accumulator.sv
// Directed bench for simd_accumulator: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_simd_accumulator;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        sclr = 1'b0;
  logic        ce = 1'b1;
  logic        active_chain = 1'b1;
  logic [3:0]  select_precision = 4'h1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [63:0] res_mac_p = '0;
  logic        in_ready;
  logic [63:0] acc_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  overflow;
  logic [7:0]  beat_count;

  int n_pass = 0;
  int n_total = 0;

  simd_accumulator #(.DATA_WIDTH(64), .CNT_WIDTH(8)) dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .sclr             (sclr),
    .ce               (ce),
    .active_chain     (active_chain),
    .select_precision (select_precision),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .res_mac_p        (res_mac_p),
    .in_ready         (in_ready),
    .acc_out          (acc_out),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .overflow         (overflow),
    .beat_count       (beat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic last);
    in_valid  = 1'b1;
    res_mac_p = d;
    in_last   = last;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick(); tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (acc_out !== 64'h0) $display("FAIL rst_acc_out got=%h exp=0", acc_out); else n_pass++;
    n_total++; if (overflow !== 8'h00) $display("FAIL rst_overflow got=%h exp=00", overflow); else n_pass++;
    n_total++; if (beat_count !== 8'd0) $display("FAIL rst_beat_count got=%0d exp=0", beat_count); else n_pass++;
    aresetn = 1'b1;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready got=%b exp=1", in_ready); else n_pass++;
  endtask

  task automatic test_acc_8b();
    select_precision = 4'h1; active_chain = 1'b1;
    send({8{8'h01}}, 1'b0);
    send({8{8'h01}}, 1'b0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL acc8_early_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (beat_count !== 8'd2) $display("FAIL acc8_count2 got=%0d exp=2", beat_count); else n_pass++;
    send({8{8'h01}}, 1'b1);
    n_total++; if (out_valid !== 1'b1) $display("FAIL acc8_valid got=%b exp=1", out_valid); else n_pass++;
    n_total++; if (acc_out !== {8{8'h03}}) $display("FAIL acc8_sum got=%h exp=%h", acc_out, {8{8'h03}}); else n_pass++;
    n_total++; if (overflow !== 8'h00) $display("FAIL acc8_ovf got=%h exp=00", overflow); else n_pass++;
    n_total++; if (beat_count !== 8'd3) $display("FAIL acc8_count3 got=%0d exp=3", beat_count); else n_pass++;
    consume();
    n_total++; if (out_valid !== 1'b0) $display("FAIL acc8_consumed_valid got=%b exp=0", out_valid); else n_pass++;
    n_total++; if (beat_count !== 8'd0) $display("FAIL acc8_consumed_count got=%0d exp=0", beat_count); else n_pass++;
  endtask

  task automatic test_wrap_8b();
    select_precision = 4'h1;
    send({8{8'h7F}}, 1'b0);
    n_total++; if (overflow !== 8'h00) $display("FAIL wrap_first_ovf got=%h exp=00", overflow); else n_pass++;
    send({8{8'h01}}, 1'b1);
    n_total++; if (acc_out !== {8{8'h80}}) $display("FAIL wrap_sum got=%h exp=%h", acc_out, {8{8'h80}}); else n_pass++;
    n_total++; if (overflow !== 8'hFF) $display("FAIL wrap_ovf got=%h exp=ff", overflow); else n_pass++;
    consume();
    n_total++; if (overflow !== 8'h00) $display("FAIL wrap_ovf_cleared got=%h exp=00", overflow); else n_pass++;
  endtask

  task automatic test_prec_16b();
    select_precision = 4'h3;
    send({4{16'hCAFE}}, 1'b0);
    send({4{16'h0002}}, 1'b1);
    n_total++; if (acc_out !== {4{16'hCB00}}) $display("FAIL p16_sum got=%h exp=%h", acc_out, {4{16'hCB00}}); else n_pass++;
    n_total++; if (overflow !== 8'h00) $display("FAIL p16_ovf got=%h exp=00", overflow); else n_pass++;
    consume();
    select_precision = 4'h1;
    send({4{16'hCAFE}}, 1'b0);
    send({4{16'h0002}}, 1'b1);
    n_total++; if (acc_out !== {4{16'hCA00}}) $display("FAIL p16_as_8b_sum got=%h exp=%h", acc_out, {4{16'hCA00}}); else n_pass++;
    consume();
  endtask

  task automatic test_prec_64b();
    select_precision = 4'hF;
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'h1, 1'b1);
    n_total++; if (acc_out !== 64'h0) $display("FAIL p64_wrap_sum got=%h exp=0", acc_out); else n_pass++;
    n_total++; if (overflow !== 8'h00) $display("FAIL p64_wrap_ovf got=%h exp=00", overflow); else n_pass++;
    consume();
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    send(64'h1, 1'b1);
    n_total++; if (acc_out !== 64'h8000_0000_0000_0000) $display("FAIL p64_ovf_sum got=%h exp=8000000000000000", acc_out); else n_pass++;
    n_total++; if (overflow !== 8'h80) $display("FAIL p64_ovf got=%h exp=80", overflow); else n_pass++;
    consume();
  endtask

  task automatic test_pass_through();
    active_chain = 1'b0; select_precision = 4'h1; out_ready = 1'b1;
    in_valid = 1'b1; in_last = 1'b0; res_mac_p = 64'h1234;
    tick();
    n_total++; if (out_valid !== 1'b1 || acc_out !== 64'h1234) $display("FAIL pt_first got=%b/%h exp=1/1234", out_valid, acc_out); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL pt_hold_ready got=%b exp=0", in_ready); else n_pass++;
    res_mac_p = 64'h5678;
    tick();
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL pt_bubble got valid=%b ready=%b exp 0/1", out_valid, in_ready); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1 || acc_out !== 64'h5678) $display("FAIL pt_second got=%b/%h exp=1/5678", out_valid, acc_out); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL pt_drained got=%b exp=0", out_valid); else n_pass++;
    out_ready = 1'b0; active_chain = 1'b1;
  endtask

  task automatic test_backpressure();
    select_precision = 4'h1;
    send({8{8'h01}}, 1'b0);
    select_precision = 4'hF;
    send({8{8'hFF}}, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL bp_hold cyc=%0d got ready=%b valid=%b exp 0/1", i, in_ready, out_valid); else n_pass++;
      n_total++; if (acc_out !== 64'h0) $display("FAIL bp_prec_ignored cyc=%0d got=%h exp=0", i, acc_out); else n_pass++;
      tick();
    end
    consume();
    select_precision = 4'h1;
  endtask

  task automatic test_ce();
    send({8{8'h01}}, 1'b0);
    ce = 1'b0; in_valid = 1'b1; res_mac_p = {8{8'h10}}; in_last = 1'b1;
    tick(); tick();
    n_total++; if (beat_count !== 8'd1 || out_valid !== 1'b0) $display("FAIL ce_frozen got cnt=%0d valid=%b exp 1/0", beat_count, out_valid); else n_pass++;
    in_valid = 1'b0; in_last = 1'b0; ce = 1'b1;
    send({8{8'h02}}, 1'b1);
    n_total++; if (acc_out !== {8{8'h03}}) $display("FAIL ce_sum got=%h exp=%h", acc_out, {8{8'h03}}); else n_pass++;
    ce = 1'b0; out_ready = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL ce_no_consume got=%b exp=1", out_valid); else n_pass++;
    ce = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL ce_consume got=%b exp=0", out_valid); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_sclr();
    send({8{8'h01}}, 1'b0);
    sclr = 1'b1; in_valid = 1'b1; res_mac_p = {8{8'h01}}; in_last = 1'b1;
    tick();
    sclr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    n_total++; if (beat_count !== 8'd0 || out_valid !== 1'b0) $display("FAIL sclr_state got cnt=%0d valid=%b exp 0/0", beat_count, out_valid); else n_pass++;
    n_total++; if (acc_out !== 64'h0) $display("FAIL sclr_acc_out got=%h exp=0", acc_out); else n_pass++;
    send({8{8'h04}}, 1'b1);
    n_total++; if (acc_out !== {8{8'h04}}) $display("FAIL sclr_clean got=%h exp=%h", acc_out, {8{8'h04}}); else n_pass++;
    consume();
  endtask

  task automatic test_async_reset();
    send({8{8'h01}}, 1'b0);
    send({8{8'h01}}, 1'b1);
    consume();
    send({8{8'h01}}, 1'b0);
    send({8{8'h01}}, 1'b0);
    n_total++; if (beat_count !== 8'd2) $display("FAIL ar_count got=%0d exp=2", beat_count); else n_pass++;
    aresetn = 1'b0;
    #2;
    n_total++; if (acc_out !== 64'h0 || beat_count !== 8'd0) $display("FAIL ar_cleared got acc=%h cnt=%0d exp 0/0", acc_out, beat_count); else n_pass++;
    n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || overflow !== 8'h00) $display("FAIL ar_flags got ready=%b valid=%b ovf=%h exp 0/0/00", in_ready, out_valid, overflow); else n_pass++;
    #2;
    aresetn = 1'b1;
    tick();
    send({8{8'h05}}, 1'b1);
    n_total++; if (acc_out !== {8{8'h05}} || beat_count !== 8'd1) $display("FAIL ar_next got acc=%h cnt=%0d exp %h/1", acc_out, beat_count, {8{8'h05}}); else n_pass++;
    consume();
  endtask

  task automatic test_force_close();
    select_precision = 4'h1;
    for (int i = 0; i < 254; i++) send({8{8'h01}}, 1'b0);
    n_total++; if (out_valid !== 1'b0 || beat_count !== 8'd254) $display("FAIL fc_254 got valid=%b cnt=%0d exp 0/254", out_valid, beat_count); else n_pass++;
    send({8{8'h01}}, 1'b0);
    n_total++; if (out_valid !== 1'b1 || beat_count !== 8'd255) $display("FAIL fc_closed got valid=%b cnt=%0d exp 1/255", out_valid, beat_count); else n_pass++;
    n_total++; if (acc_out !== {8{8'hFF}} || overflow !== 8'hFF) $display("FAIL fc_sum got acc=%h ovf=%h exp %h/ff", acc_out, overflow, {8{8'hFF}}); else n_pass++;
    consume();
  endtask

  initial begin
    test_reset();
    test_acc_8b();
    test_wrap_8b();
    test_prec_16b();
    test_prec_64b();
    test_pass_through();
    test_backpressure();
    test_ce();
    test_sclr();
    test_async_reset();
    test_force_close();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
